// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
// Contents: default geometry constants, register-count and counter-limit helpers,
// and index/counter typedefs for the default configuration.
package rf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned PC_IDX_DEF = 15;
    localparam int unsigned PEND_W_DEF = 2;

    // Number of architectural registers for a given address width.
    function automatic int unsigned nregs(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Largest count a pending counter of the given width can hold.
    function automatic int unsigned pend_max(input int unsigned pend_w);
        return (32'd1 << pend_w) - 32'd1;
    endfunction

    localparam int unsigned PEND_MAX = (1 << PEND_W_DEF) - 1;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports with ready flags, the issue handshake and
// the writeback strobe.
//   master : core side (drives addresses, issue request, writeback)
//   slave  : register file (returns read data, ready flags, iss_ready)
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd1_rdy;
    logic              rd2_rdy;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_dst;
    logic              iss_ready;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output ra1, ra2, iss_valid, iss_dst, wb_en, wb_addr, wb_data,
        input  rd1, rd2, rd1_rdy, rd2_rdy, iss_ready
    );

    modport slave (
        input  ra1, ra2, iss_valid, iss_dst, wb_en, wb_addr, wb_data,
        output rd1, rd2, rd1_rdy, rd2_rdy, iss_ready
    );
endinterface

// File: rtl/rf_pend_cnt.sv
// Per-register pending-write counter, saturating in both directions.
// Ports:
//   CLK   in  clock
//   reset in  synchronous active-high reset
//   inc   in  an issue to this register was accepted
//   dec   in  a legal writeback to this register retired
//   cnt   out current count of outstanding writes
//   zero  out cnt == 0
//   full  out cnt == maximum
module rf_pend_cnt
    import rf_pkg::*;
#(
    parameter int unsigned PEND_W = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              zero,
    output logic              full
);
    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // inc together with dec leaves the count alone
        if (inc && !dec && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + PEND_W'(1);
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign full = (cnt_q == CNT_MAX);
endmodule

// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard.
// Issue marks a destination pending; writeback stores data and retires one
// pending write. Read ports flag whether their value is final. Register PC_IDX
// mirrors pc_in every cycle and is never architecturally written.
// Optional macro RF_BYPASS_EN: forward a same-cycle legal writeback to the read ports.
// Ports:
//   CLK      in  clock
//   reset    in  synchronous active-high reset
//   bus      slave side of regfile_sb_if (reads, issue, writeback)
//   pc_in    in  PC value captured into PC_IDX every cycle
//   pend_any out any register has pending writes (registered)
//   wb_err   out one-cycle pulse after an illegal writeback
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_IDX = 15,
    parameter int unsigned PEND_W = 2
) (
    input  logic              CLK,
    input  logic              reset,
    regfile_sb_if.slave       bus,
    input  logic [DATA_W-1:0] pc_in,
    output logic              pend_any,
    output logic              wb_err
);
    localparam int unsigned       NREGS = nregs(ADDR_W);
    localparam logic [ADDR_W-1:0] PC_A  = PC_IDX[ADDR_W-1:0];

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [PEND_W-1:0] cnt    [NREGS];
    logic [NREGS-1:0]  inc, dec, zero, full, nz_next;
    logic              wb_legal, iss_ok;
    logic              pend_any_q, wb_err_q;

    assign wb_legal = bus.wb_en && (bus.wb_addr != PC_A) && !zero[bus.wb_addr];
    // A full counter can still take an issue if a writeback retires one the same cycle
    assign iss_ok   = bus.iss_valid && (bus.iss_dst != PC_A) &&
                      (!full[bus.iss_dst] || (wb_legal && bus.wb_addr == bus.iss_dst));
    assign bus.iss_ready = iss_ok;

    always_comb begin
        inc = '0;
        dec = '0;
        if (iss_ok)   inc[bus.iss_dst] = 1'b1;
        if (wb_legal) dec[bus.wb_addr] = 1'b1;
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        rf_pend_cnt #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .CLK   (CLK),
            .reset (reset),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .cnt   (cnt[g]),
            .zero  (zero[g]),
            .full  (full[g])
        );
    end

    // Whether each counter is non-zero after the coming edge, for registered pend_any
    always_comb begin
        nz_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (inc[i] && !dec[i]) begin
                nz_next[i] = 1'b1;
            end else if (dec[i] && !inc[i]) begin
                nz_next[i] = (cnt[i] != PEND_W'(1));
            end else begin
                nz_next[i] = !zero[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_any_q <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            regs_q[PC_A] <= pc_in;
            if (wb_legal) begin
                regs_q[bus.wb_addr] <= bus.wb_data;
            end
            pend_any_q <= |nz_next;
            wb_err_q   <= bus.wb_en && !wb_legal;
        end
    end

    assign pend_any = pend_any_q;
    assign wb_err   = wb_err_q;

    always_comb begin
        bus.rd1     = regs_q[bus.ra1];
        bus.rd2     = regs_q[bus.ra2];
        bus.rd1_rdy = zero[bus.ra1] || (bus.ra1 == PC_A);
        bus.rd2_rdy = zero[bus.ra2] || (bus.ra2 == PC_A);
`ifdef RF_BYPASS_EN
        // Forwarded value is final only if this writeback retires the last pending write
        if (wb_legal && bus.wb_addr == bus.ra1) begin
            bus.rd1     = bus.wb_data;
            bus.rd1_rdy = (cnt[bus.ra1] == PEND_W'(1));
        end
        if (wb_legal && bus.wb_addr == bus.ra2) begin
            bus.rd2     = bus.wb_data;
            bus.rd2_rdy = (cnt[bus.ra2] == PEND_W'(1));
        end
`endif
    end
endmodule
